// File: rtl/maxpool_window_sequencer.sv
// 2x2 stride-2 max-pool controller: walks the conv feature map, folds each window
// into a signed running max and writes one pooled pixel per window.
module maxpool_window_sequencer #(
  parameter int addressWidthConv = 10,
  parameter int addressWidthPool = 8,
  parameter int dataWidthMax     = 8,
  parameter int IMG_W            = 26,
  parameter int IMG_H            = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        conv_rd_en,
  output logic [addressWidthConv-1:0] conv_raddr,
  input  logic [dataWidthMax-1:0]     rdata_conv,
  output logic                        pool_we,
  output logic [addressWidthPool-1:0] pool_waddr,
  output logic [dataWidthMax-1:0]     pool_wdata
);

  // Handshake: start is sampled only in IDLE and never queued; busy is high from the
  // first read cycle through the last write; done pulses for one cycle after that write.

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam int CW    = 16;
  localparam int AC    = addressWidthConv;
  localparam int AP    = addressWidthPool;
  localparam int DW    = dataWidthMax;

  localparam logic [CW-1:0] LAST_C  = CW'(OUT_W - 1);
  localparam logic [CW-1:0] LAST_R  = CW'(OUT_H - 1);
  localparam logic [AC-1:0] ONE     = AC'(1);
  localparam logic [AC-1:0] ROW_OFF = AC'(IMG_W);
  localparam logic [AC-1:0] STEP_C  = AC'(2);
  // From the last window of a row to the first window two rows down; skips an odd last column.
  localparam logic [AC-1:0] STEP_R  = AC'(2 * IMG_W - 2 * (OUT_W - 1));

  typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

  state_t          state;
  logic [1:0]      tap;
  logic [CW-1:0]   r;
  logic [CW-1:0]   c;
  logic [AC-1:0]   base;
  logic [AP-1:0]   out_idx;
  logic [DW-1:0]   max_reg;

  logic [1:0]      tap_next;
  logic [AC-1:0]   rd_next;
  logic [AC-1:0]   next_base;
  logic [DW-1:0]   folded;
  logic            first_fold;
  logic            last_col;
  logic            last_win;

  always_comb begin
    tap_next = tap + 2'd1;
    case (tap_next)
      2'd0:    rd_next = base;
      2'd1:    rd_next = base + ONE;
      2'd2:    rd_next = base + ROW_OFF;
      default: rd_next = base + ROW_OFF + ONE;
    endcase
    // Tap 0 data arrives while tap 1 is being issued and loads unconditionally.
    first_fold = (state == RD) && (tap == 2'd1);
    if (first_fold || ($signed(rdata_conv) > $signed(max_reg))) folded = rdata_conv;
    else                                                          folded = max_reg;
    last_col  = (c == LAST_C);
    last_win  = last_col && (r == LAST_R);
    next_base = last_col ? (base + STEP_R) : (base + STEP_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tap        <= 2'd0;
      r          <= '0;
      c          <= '0;
      base       <= '0;
      out_idx    <= '0;
      max_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      conv_rd_en <= 1'b0;
      conv_raddr <= '0;
      pool_we    <= 1'b0;
      pool_waddr <= '0;
      pool_wdata <= '0;
    end else begin
      done    <= 1'b0;
      pool_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r          <= '0;
            c          <= '0;
            tap        <= 2'd0;
            base       <= '0;
            out_idx    <= '0;
            conv_rd_en <= 1'b1;
            conv_raddr <= '0;
            busy       <= 1'b1;
            state      <= RD;
          end
        end
        RD: begin
          if (tap != 2'd0) max_reg <= folded;
          if (tap == 2'd3) begin
            conv_rd_en <= 1'b0;
            conv_raddr <= '0;
            state      <= LAST;
          end else begin
            tap        <= tap_next;
            conv_raddr <= rd_next;
          end
        end
        LAST: begin
          max_reg    <= folded;
          pool_we    <= 1'b1;
          pool_wdata <= folded;
          pool_waddr <= out_idx;
          state      <= WR;
        end
        WR: begin
          tap     <= 2'd0;
          out_idx <= out_idx + AP'(1);
          if (last_win) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (last_col) begin
              c <= '0;
              r <= r + CW'(1);
            end else begin
              c <= c + CW'(1);
            end
            base       <= next_base;
            conv_rd_en <= 1'b1;
            conv_raddr <= next_base;
            state      <= RD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Bench for maxpool_window_sequencer: three instances (4x4, 5x5, 26x26) against a
// window-max reference model, plus timing, restart-ignore and mid-run reset checks.
module tb_maxpool_window_sequencer;

  localparam int NDUT   = 3;
  localparam int MAXPIX = 676;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_v [NDUT];
  logic       rst_v   [NDUT];
  logic       busy_v  [NDUT];
  logic       done_v  [NDUT];
  logic       rd_en_v [NDUT];
  logic       we_v    [NDUT];
  logic [9:0] raddr_v [NDUT];
  logic [7:0] rdata_v [NDUT];
  logic [7:0] waddr_v [NDUT];
  logic [7:0] wdata_v [NDUT];
  logic [7:0] mem     [NDUT][MAXPIX];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 5 : 26);
    maxpool_window_sequencer #(
      .addressWidthConv(10), .addressWidthPool(8), .dataWidthMax(8), .IMG_W(D), .IMG_H(D)
    ) u_dut (
      .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .conv_rd_en(rd_en_v[g]), .conv_raddr(raddr_v[g]), .rdata_conv(rdata_v[g]),
      .pool_we(we_v[g]), .pool_waddr(waddr_v[g]), .pool_wdata(wdata_v[g])
    );
  end

  // Conv RAM models with a one-cycle synchronous read.
  always_ff @(posedge clk) begin
    for (int g = 0; g < NDUT; g++)
      if (rd_en_v[g]) rdata_v[g] <= mem[g][raddr_v[g]];
  end

  // Observers on the falling edge.
  logic       clr_v     [NDUT];
  int         wr_cnt    [NDUT];
  int         done_cnt  [NDUT];
  int         done_cyc  [NDUT];
  int         rd_bad    [NDUT];
  logic       busy_done [NDUT];
  logic [7:0] wr_addr   [NDUT][256];
  logic [7:0] wr_data   [NDUT][256];
  logic       touched   [NDUT][MAXPIX];

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (clr_v[g]) begin
        wr_cnt[g] = 0; done_cnt[g] = 0; done_cyc[g] = 0; rd_bad[g] = 0; busy_done[g] = 1'b0;
        for (int i = 0; i < MAXPIX; i++) touched[g][i] = 1'b0;
      end else begin
        if (we_v[g]) begin
          if (wr_cnt[g] < 256) begin
            wr_addr[g][wr_cnt[g]] = waddr_v[g];
            wr_data[g][wr_cnt[g]] = wdata_v[g];
          end
          wr_cnt[g]++;
        end
        if (done_v[g]) begin
          done_cnt[g]++;
          done_cyc[g]  = cyc;
          busy_done[g] = busy_v[g];
        end
        if (rd_en_v[g]) begin
          if (int'(raddr_v[g]) < MAXPIX) touched[g][raddr_v[g]] = 1'b1;
          else rd_bad[g]++;
        end else if (raddr_v[g] != 10'd0) begin
          rd_bad[g]++;
        end
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int g);
    clr_v[g] = 1'b1;
    @(negedge clk);
    #1;
    clr_v[g] = 1'b0;
  endtask

  // Returns with the bench in cycle 1 of the pass; s0 is cyc during that cycle.
  task automatic start_pass(input int g, output int s0);
    clear_mon(g);
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
    s0 = cyc;
    check("busy_c1",  32'(busy_v[g]),  32'd1);
    check("rden_c1",  32'(rd_en_v[g]), 32'd1);
    check("raddr_c1", 32'(raddr_v[g]), 32'd0);
  endtask

  task automatic wait_done(input int g, input int restart_at, input int budget);
    int k = 1;
    while (done_cnt[g] == 0 && k < budget) begin
      start_v[g] = (k == restart_at);
      @(posedge clk);
      #1;
      k++;
    end
    start_v[g] = 1'b0;
    check("done_seen", 32'(done_cnt[g]), 32'd1);
  endtask

  task automatic check_end(input int g, input int dim, input int s0);
    int ow = dim / 2;
    repeat (8) @(posedge clk);
    #1;
    check("done_once",  32'(done_cnt[g]), 32'd1);
    check("done_cycle", 32'(done_cyc[g] - s0 + 1), 32'(1 + 6 * ow * ow));
    check("busy_at_done", 32'(busy_done[g]), 32'd0);
    check("busy_after", 32'(busy_v[g]), 32'd0);
    check("raddr_rules", 32'(rd_bad[g]), 32'd0);
  endtask

  // Reference: each window's value is the signed max over its four pixels.
  task automatic check_writes(input int g, input int dim);
    logic [15:0] exp_q[$];
    logic [7:0]  mx, v;
    int ow = dim / 2;
    int n;
    for (int r = 0; r < ow; r++) begin
      for (int c = 0; c < ow; c++) begin
        mx = mem[g][2 * r * dim + 2 * c];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = mem[g][(2 * r + dr) * dim + 2 * c + dc];
            if ($signed(v) > $signed(mx)) mx = v;
          end
        exp_q.push_back({8'(r * ow + c), mx});
      end
    end
    check("wr_count", 32'(wr_cnt[g]), 32'(exp_q.size()));
    n = (wr_cnt[g] < exp_q.size()) ? wr_cnt[g] : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[g][i]), 32'(exp_q[i][15:8]));
      check($sformatf("wr_data[%0d]", i), 32'(wr_data[g][i]), 32'(exp_q[i][7:0]));
    end
  endtask

  task automatic fill_random(input int g);
    for (int i = 0; i < MAXPIX; i++) mem[g][i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int s0;
    int bad;
    int hit;
    for (int g = 0; g < NDUT; g++) begin
      rst_v[g] = 1'b1; start_v[g] = 1'b0; clr_v[g] = 1'b1;
      for (int i = 0; i < MAXPIX; i++) mem[g][i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      rst_v[g] = 1'b0;
      clr_v[g] = 1'b0;
    end
    for (int g = 0; g < NDUT; g++) begin
      check("rst_busy",  32'(busy_v[g]),  32'd0);
      check("rst_done",  32'(done_v[g]),  32'd0);
      check("rst_rden",  32'(rd_en_v[g]), 32'd0);
      check("rst_we",    32'(we_v[g]),    32'd0);
      check("rst_raddr", 32'(raddr_v[g]), 32'd0);
      check("rst_waddr", 32'(waddr_v[g]), 32'd0);
      check("rst_wdata", 32'(wdata_v[g]), 32'd0);
    end

    // 4x4 ramp map
    for (int i = 0; i < 16; i++) mem[0][i] = 8'(i);
    start_pass(0, s0);
    wait_done(0, 0, 200);
    check_end(0, 4, s0);
    check_writes(0, 4);
    check("ramp_w0", 32'(wr_data[0][0]), 32'd5);
    check("ramp_w1", 32'(wr_data[0][1]), 32'd7);
    check("ramp_w2", 32'(wr_data[0][2]), 32'd13);
    check("ramp_w3", 32'(wr_data[0][3]), 32'd15);

    // 4x4 signed windows
    fill_random(0);
    mem[0][0] = 8'h80; mem[0][1] = 8'hFF; mem[0][4] = 8'hFB; mem[0][5] = 8'hFF;
    mem[0][2] = 8'hFD; mem[0][3] = 8'hF9; mem[0][6] = 8'hFE; mem[0][7] = 8'hF7;
    start_pass(0, s0);
    wait_done(0, 0, 200);
    check_end(0, 4, s0);
    check_writes(0, 4);
    check("signed_w0", 32'(wr_data[0][0]), 32'hFF);
    check("signed_w1", 32'(wr_data[0][1]), 32'hFE);

    // 5x5: odd last row/column never read
    fill_random(1);
    start_pass(1, s0);
    wait_done(1, 0, 200);
    check_end(1, 5, s0);
    check_writes(1, 5);
    check("odd_wr_count", 32'(wr_cnt[1]), 32'd4);
    bad = 0;
    hit = 0;
    for (int i = 0; i < 25; i++) begin
      if (touched[1][i]) hit++;
      if (touched[1][i] && (i % 5 == 4 || i / 5 == 4)) bad++;
    end
    check("odd_edge_reads", 32'(bad), 32'd0);
    check("odd_read_count", 32'(hit), 32'd16);

    // 26x26 with an ignored start pulse at cycle 100
    fill_random(2);
    start_pass(2, s0);
    wait_done(2, 100, 1200);
    check_end(2, 26, s0);
    check("full_done_1015", 32'(done_cyc[2] - s0 + 1), 32'd1015);
    check_writes(2, 26);

    // 26x26 with reset at cycle 50, then a clean pass
    start_pass(2, s0);
    repeat (49) @(posedge clk);
    #1;
    rst_v[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[2] = 1'b0;
    check("rst_mid_busy", 32'(busy_v[2]),  32'd0);
    check("rst_mid_rden", 32'(rd_en_v[2]), 32'd0);
    check("rst_mid_wrs",  32'(wr_cnt[2]),  32'd8);
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_more_wr", 32'(wr_cnt[2]),   32'd8);
    check("rst_no_done",    32'(done_cnt[2]), 32'd0);
    fill_random(2);
    start_pass(2, s0);
    wait_done(2, 0, 1200);
    check_end(2, 26, s0);
    check_writes(2, 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
